// File: rtl/norm_sched_pkg.sv
// Shared constants for the normalisation job scheduler: default parameter
// values and the scheduler FSM state encoding.
package norm_sched_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NREQ    = 2;
  localparam int DEF_WORDS   = 192;
  localparam int DEF_BATCHES = 6;
  localparam int DEF_TIMEOUT = 4096;

  // Scheduler state encoding, exposed on dbg_state.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_WAIT  = 3'd2;
  localparam state_t S_DRAIN = 3'd3;
  localparam state_t S_RESP  = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request found
// when scanning upward (with wrap) from the index after last_ptr.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IW-1:0]   gnt_idx
);

  // Scan farthest-to-nearest so the nearest active request is written last.
  always_comb begin
    int idx;
    gnt_oh  = '0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(last_ptr) + i) % NREQ;
      if (req[idx]) begin
        gnt_oh      = '0;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/norm_job_sched.sv
// Normalisation job scheduler. Grants one requester at a time (round
// robin), streams its WORDS words into the accelerator, acknowledges
// BATCHES per-batch completions, then reads the results back and returns
// them one response at a time. A watchdog aborts a job whose accelerator
// stops producing batch completions.
//
// Handshakes: every valid/ready pair transfers on a rising edge where both
// are 1; a valid, once raised, holds its payload stable until accepted.
// The load path (in_* <-> acc_input_*) is a zero-latency pass-through of
// the granted requester, so its stability follows the requester's.
module norm_job_sched
  import norm_sched_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREQ    = DEF_NREQ,
  parameter int WORDS   = DEF_WORDS,
  parameter int BATCHES = DEF_BATCHES,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            in_valid,
  input  logic [NREQ*WIDTH-1:0]      in_data,
  output logic [NREQ-1:0]            in_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       rsp_last,
  output logic                       rsp_err,
  output logic                       acc_input_valid,
  input  logic                       acc_input_ready,
  output logic [WIDTH-1:0]           acc_ax,
  input  logic                       acc_output_valid,
  output logic                       acc_output_ready,
  input  logic                       acc_busy,
  output logic [5:0]                 acc_dp_read_addr,
  input  logic [2*WIDTH-1:0]         acc_res,
  output state_t                     dbg_state
);

  localparam int IW  = $clog2(NREQ);
  localparam int WCW = $clog2(WORDS + 1);
  localparam int BCW = $clog2(BATCHES + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    gnt_q, gnt_d, last_q, last_d;
  logic [WCW-1:0]   word_q, word_d;
  logic [BCW-1:0]   batch_q, batch_d;
  logic [TW-1:0]    wd_q, wd_d;
  logic [5:0]       rd_idx_q, rd_idx_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_last_q, rsp_last_d, rsp_err_q, rsp_err_d;

  logic [NREQ-1:0]  arb_gnt_oh;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic             unused_res_hi;

  // Only the low word of each accelerator result is returned.
  assign unused_res_hi = ^acc_res[2*WIDTH-1:WIDTH];

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req      (in_valid),
    .last_ptr (last_q),
    .gnt_oh   (arb_gnt_oh),
    .gnt_idx  (arb_idx)
  );

  assign arb_any = |arb_gnt_oh;

  // Datapath steering and handshake outputs, decoded from the current state.
  always_comb begin
    in_ready         = '0;
    acc_input_valid  = 1'b0;
    acc_ax           = '0;
    acc_output_ready = 1'b0;
    acc_dp_read_addr = '0;
    case (state_q)
      S_LOAD: begin
        acc_input_valid = in_valid[gnt_q];
        acc_ax          = in_data[int'(gnt_q)*WIDTH +: WIDTH];
        in_ready[gnt_q] = acc_input_ready;
      end
      S_WAIT:  acc_output_ready = acc_output_valid;
      S_DRAIN: acc_dp_read_addr = rd_idx_q;
      default: ;
    endcase
    rsp_valid = (state_q == S_RESP);
    rsp_data  = rsp_valid ? rsp_data_q : '0;
    rsp_last  = rsp_valid & rsp_last_q;
    rsp_err   = rsp_valid & rsp_err_q;
    rsp_id    = rsp_valid ? gnt_q : '0;
    dbg_state = state_q;
  end

  // Next-state, counters, watchdog and response capture.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    word_d     = word_q;
    batch_d    = batch_q;
    wd_d       = wd_q;
    rd_idx_d   = rd_idx_q;
    rsp_data_d = rsp_data_q;
    rsp_last_d = rsp_last_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (!acc_busy && arb_any) begin
          gnt_d   = arb_idx;
          last_d  = arb_idx;
          word_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (acc_input_valid && acc_input_ready) begin
          if (word_q == WCW'(WORDS - 1)) begin
            word_d  = '0;
            batch_d = '0;
            wd_d    = '0;
            state_d = S_WAIT;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (acc_output_valid) begin
          wd_d = '0;
          if (batch_q == BCW'(BATCHES - 1)) begin
            batch_d  = '0;
            rd_idx_d = '0;
            state_d  = S_DRAIN;
          end else begin
            batch_d = batch_q + 1'b1;
          end
        end else if (wd_q == TW'(TIMEOUT - 1)) begin
          wd_d       = '0;
          rsp_data_d = '0;
          rsp_last_d = 1'b1;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_DRAIN: begin
        rsp_data_d = acc_res[WIDTH-1:0];
        rsp_last_d = (rd_idx_q == 6'(BATCHES - 1));
        rsp_err_d  = 1'b0;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (rsp_last_q) begin
            state_d = S_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 6'd1;
            state_d  = S_DRAIN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      last_q     <= IW'(NREQ - 1);
      word_q     <= '0;
      batch_q    <= '0;
      wd_q       <= '0;
      rd_idx_q   <= '0;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      word_q     <= word_d;
      batch_q    <= batch_d;
      wd_q       <= wd_d;
      rd_idx_q   <= rd_idx_d;
      rsp_data_q <= rsp_data_d;
      rsp_last_q <= rsp_last_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_norm_job_sched.sv
// Bench for norm_job_sched: requester drivers, a behavioural accelerator
// (each batch result is clog2 of the sum of its 32 words), and a response
// scoreboard fed by the directed tests.
module tb_norm_job_sched;
  import norm_sched_pkg::*;

  localparam int WIDTH   = 32;
  localparam int NREQ    = 2;
  localparam int WORDS   = 192;
  localparam int BATCHES = 6;
  localparam int TIMEOUT = 4096;
  localparam int IW      = 1;
  localparam int PER     = WORDS / BATCHES;
  localparam int W       = WIDTH + 2 + IW;

  // ---------------- clock / reset ----------------
  logic clk, rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       in_valid, in_ready;
  logic [NREQ*WIDTH-1:0] in_data;
  logic                  rsp_valid, rsp_ready, rsp_last, rsp_err;
  logic [IW-1:0]         rsp_id;
  logic [WIDTH-1:0]      rsp_data, acc_ax;
  logic                  acc_input_valid, acc_input_ready;
  logic                  acc_output_valid, acc_output_ready, acc_busy;
  logic [5:0]            acc_dp_read_addr;
  logic [2*WIDTH-1:0]    acc_res;
  state_t                dbg_state;

  norm_job_sched #(
    .WIDTH(WIDTH), .NREQ(NREQ), .WORDS(WORDS), .BATCHES(BATCHES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .acc_input_valid(acc_input_valid), .acc_input_ready(acc_input_ready),
    .acc_ax(acc_ax), .acc_output_valid(acc_output_valid),
    .acc_output_ready(acc_output_ready), .acc_busy(acc_busy),
    .acc_dp_read_addr(acc_dp_read_addr), .acc_res(acc_res),
    .dbg_state(dbg_state)
  );

  // ---------------- bench state ----------------
  int               n_cmp = 0, n_err = 0;
  logic [W-1:0]     exp_q[$];
  int               rem[NREQ];
  logic [WIDTH-1:0] val[NREQ];
  logic [NREQ-1:0]  fire;
  bit               toggle, phase, no_out, chk_r1;
  int               loaded, out_pending, words_job, bad_rdy, bad_r1;
  int               sums[BATCHES];
  logic [WIDTH-1:0] res_mem[64];
  state_t           prev_state;

  assign acc_res = {{WIDTH{1'b0}}, res_mem[acc_dp_read_addr]};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_job(input int k, input logic [WIDTH-1:0] v);
    val[k] = v;
    rem[k] = WORDS;
  endtask

  task automatic push_job(input int id, input logic [WIDTH-1:0] data);
    for (int b = 0; b < BATCHES; b++)
      exp_q.push_back({1'b0, 1'(b == BATCHES - 1), IW'(id), data});
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int  c;
    bit  done;
    c = 0;
    done = 1'b0;
    while (!done && c < max_cyc) begin
      @(negedge clk);
      c++;
      done = (exp_q.size() == 0) && (dbg_state == S_IDLE) && (rem[0] == 0) &&
             (rem[1] == 0) && (out_pending == 0);
    end
    chk({name, "_completes"}, 64'(done), 64'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_rsp_flags"}, 64'({rsp_last, rsp_err}), 64'd0);
    chk({tag, "_acc_in"}, 64'({acc_input_valid, acc_ax}), 64'd0);
    chk({tag, "_acc_out_rdy"}, 64'(acc_output_ready), 64'd0);
    chk({tag, "_rd_addr"}, 64'(acc_dp_read_addr), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'(S_IDLE));
  endtask

  // Requesters and accelerator outputs change just after the rising edge.
  always @(posedge clk) begin
    #1;
    phase = ~phase;
    for (int k = 0; k < NREQ; k++) begin
      if (fire[k] && rem[k] > 0) rem[k]--;
      in_valid[k] = (rem[k] > 0) && (!toggle || phase);
      in_data[k*WIDTH +: WIDTH] = val[k];
    end
    fire = '0;
    acc_output_valid = (out_pending > 0);
    acc_busy         = (out_pending > 0);
  end

  // Accelerator model plus response monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      loaded = 0; out_pending = 0; words_job = 0; fire = '0;
      for (int b = 0; b < BATCHES; b++) sums[b] = 0;
      prev_state = S_IDLE;
    end else begin
      fire = in_valid & in_ready;
      if (acc_input_valid && acc_input_ready) begin
        sums[loaded / PER] += int'(acc_ax);
        loaded++;
        words_job++;
        if (loaded == WORDS) begin
          for (int b = 0; b < BATCHES; b++) begin
            res_mem[b] = WIDTH'($clog2(sums[b]));
            sums[b] = 0;
          end
          loaded = 0;
          if (!no_out) out_pending = BATCHES;
        end
      end
      if (acc_output_valid && acc_output_ready && out_pending > 0) out_pending--;
      if (rsp_valid && rsp_ready) begin
        logic [W-1:0] got, exp;
        got = {rsp_err, rsp_last, rsp_id, rsp_data};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rsp_unexpected: got err=%0b last=%0b id=%0d data=%0d, expected none",
                   rsp_err, rsp_last, rsp_id, rsp_data);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_err++;
            $display("FAIL rsp: got err=%0b last=%0b id=%0d data=%0d expected err=%0b last=%0b id=%0d data=%0d",
                     rsp_err, rsp_last, rsp_id, rsp_data,
                     exp[W-1], exp[W-2], exp[WIDTH+IW-1:WIDTH], exp[WIDTH-1:0]);
          end
        end
      end
      if (dbg_state == S_WAIT && prev_state != S_WAIT) begin
        chk("words_at_wait", 64'(words_job), 64'(WORDS));
        words_job = 0;
      end
      if ($countones(in_ready) > 1 || (in_ready != '0 && dbg_state != S_LOAD)) bad_rdy++;
      if (chk_r1 && in_ready[1]) bad_r1++;
      prev_state = dbg_state;
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    int c;
    rst_n = 1'b0; rsp_ready = 1'b1; acc_input_ready = 1'b1;
    acc_output_valid = 1'b0; acc_busy = 1'b0;
    in_valid = '0; in_data = '0; fire = '0; toggle = 0; phase = 0; no_out = 0; chk_r1 = 0;
    bad_rdy = 0; bad_r1 = 0;
    for (int k = 0; k < NREQ; k++) begin rem[k] = 0; val[k] = '0; end
    for (int a = 0; a < 64; a++) res_mem[a] = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // single job, requester 0, words of 1 -> six results of 5
    @(negedge clk);
    start_job(0, 1);
    push_job(0, 5);
    wait_idle("single", 2000);

    // contention from reset: requester 0 first, then requester 1
    rst_n = 1'b0;
    start_job(0, 1);
    start_job(1, 2);
    push_job(0, 5);
    push_job(1, 6);
    chk_r1 = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    while (exp_q.size() > BATCHES && c < 2000) begin @(negedge clk); c++; end
    chk("contention_job0_done", 64'(exp_q.size() <= BATCHES), 64'd1);
    chk_r1 = 0;
    wait_idle("contention", 2000);
    chk("contention_r1_ready_in_job0", 64'(bad_r1), 64'd0);

    // backpressure: first response held for 10 cycles
    rsp_ready = 1'b0;
    start_job(1, 1);
    push_job(1, 5);
    c = 0;
    while (!rsp_valid && c < 2000) begin @(negedge clk); c++; end
    chk("bp_rsp_seen", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_data", 64'(rsp_data), 64'd5);
      chk("bp_id", 64'(rsp_id), 64'd1);
      chk("bp_last", 64'(rsp_last), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_idle("backpressure", 2000);

    // watchdog: accelerator never reports a batch
    no_out = 1;
    @(negedge clk);
    start_job(0, 1);
    exp_q.push_back({1'b1, 1'b1, IW'(0), WIDTH'(0)});
    wait_idle("watchdog", TIMEOUT + 2000);
    no_out = 0;

    // load stall: requester valid every other cycle, words of 3 -> 7
    toggle = 1;
    @(negedge clk);
    start_job(1, 3);
    push_job(1, 7);
    wait_idle("stall", 3000);
    toggle = 0;

    // reset during load at word 100, then a clean job
    @(negedge clk);
    start_job(0, 1);
    c = 0;
    while (words_job < 100 && c < 2000) begin @(negedge clk); #1; c++; end
    chk("midload_reached_100", 64'(words_job), 64'd100);
    rst_n = 1'b0;
    rem[0] = 0;
    #1;
    chk_outputs_zero("midload_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midload_no_rsp_pending", 64'(exp_q.size()), 64'd0);
    start_job(0, 2);
    push_job(0, 6);
    wait_idle("after_reset", 2000);

    chk("in_ready_onehot_load_only", 64'(bad_rdy), 64'd0);
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/norm_job_sched.md
NORM_JOB_SCHED -- requirements
Module: norm_job_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data word width.
REQ-002 The block SHALL have parameter NREQ, default 2, giving the number of requesters.
REQ-003 The block SHALL have parameter WORDS, default 192, giving the number of words per job.
REQ-004 The block SHALL have parameter BATCHES, default 6, giving the number of results per job.
REQ-005 The block SHALL have parameter TIMEOUT, default 4096, giving the watchdog limit in cycles.
REQ-006 clock  in  1  sole clock; one clock; all state on rising edge.
REQ-007 reset  in  1  reset is asynchronous and active-low.
REQ-008 in_valid  in  NREQ  per-requester word valid.
REQ-009 in_data  in  NREQ*WIDTH  per-requester word; requester k occupies slice k.
REQ-010 in_ready  out  NREQ  per-requester word accept.
REQ-011 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-012 rsp_id  out  $clog2(NREQ)  requester that owns the response.
REQ-013 rsp_data  out  WIDTH  batch result.
REQ-014 rsp_last / rsp_err  out  1 / 1  final response of job / watchdog abort.
REQ-015 acc_input_valid / acc_input_ready  out / in  1 / 1  accelerator load handshake.
REQ-016 acc_ax  out  WIDTH  accelerator load word.
REQ-017 acc_output_valid / acc_output_ready  in / out  1 / 1  accelerator per-batch handshake.
REQ-018 acc_busy  in  1  accelerator not idle.
REQ-019 acc_dp_read_addr / acc_res  out / in  6 / 2*WIDTH  result read port; acc_res is combinational on the address.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD, WAIT, DRAIN and RESP.
REQ-021 In IDLE, when acc_busy=0 and any in_valid=1, the block SHALL latch a round-robin grant, with priority starting after the last granted index, and move to LOAD.
REQ-022 In IDLE, when acc_busy=1, the block SHALL make no grant.
REQ-023 In LOAD, the block SHALL drive acc_input_valid=in_valid[g], acc_ax=in_data[g] and in_ready[g]=acc_input_ready, combinationally with zero latency.
REQ-024 In all other states, and for every non-granted requester in any state, in_ready SHALL be 0.
REQ-025 A word SHALL count only on a cycle where acc_input_valid and acc_input_ready are both 1.
REQ-026 On the WORDS-th counted word the block SHALL move to WAIT.
REQ-027 In WAIT, acc_output_ready SHALL equal acc_output_valid, giving a same-cycle acknowledge.
REQ-028 Each acknowledge SHALL increment the batch count; on the BATCHES-th acknowledge the block SHALL move to DRAIN with rd_idx=0.
REQ-029 The watchdog SHALL count cycles in WAIT since the last acknowledge and SHALL clear on each acknowledge.
REQ-030 On reaching TIMEOUT the block SHALL go to RESP with rsp_err=1, rsp_last=1, rsp_data=0 and rsp_id=g.
REQ-031 In DRAIN, acc_dp_read_addr SHALL equal rd_idx, and the block SHALL register acc_res[WIDTH-1:0] into rsp_data, with rsp_last=(rd_idx==BATCHES-1), then move to RESP.
REQ-032 In RESP, rsp_valid SHALL be 1, and rsp_data, rsp_id, rsp_last and rsp_err SHALL remain stable until rsp_ready=1.
REQ-033 On RESP with rsp_ready=1: if rsp_last=1 the block SHALL go to IDLE, otherwise rd_idx SHALL increment and the block SHALL return to DRAIN.
REQ-034 Each result SHALL therefore take at least 2 cycles.
REQ-035 A requester deasserting in_valid mid-LOAD SHALL stall the load without releasing the grant.
REQ-036 acc_dp_read_addr SHALL be 0 outside DRAIN.
REQ-037 acc_output_ready SHALL be 0 outside WAIT.

Reset
REQ-038 While reset=0, the block SHALL be in IDLE with all outputs 0, counters 0, grant 0 and the last-grant pointer at NREQ-1.
REQ-039 Reset mid-job SHALL abandon the job and emit no response.

Structure
REQ-040 The state enum and the default constants SHALL live in the shared package norm_sched_pkg.
REQ-041 The round-robin arbiter SHALL be the single sub-module rr_arbiter, parameterised on NREQ, with a one-hot grant from the request vector and the last-grant pointer.

Verification
REQ-042 The bench SHALL cover a single job: requester 0 streams 192 words of value 1 → 6 responses (results 5,5,5,5,5,5 from the model), rsp_id=0, rsp_last only on the 6th, rsp_err=0.
REQ-043 The bench SHALL cover contention: both in_valid=1 from reset → requester 0 served first, then requester 1 with no overlap and in_ready[1]=0 throughout job 0.
REQ-044 The bench SHALL cover backpressure: rsp_ready held 0 for 10 cycles in RESP → rsp_data and rsp_id stable, no advance of rd_idx.
REQ-045 The bench SHALL cover the watchdog: the model never asserts acc_output_valid → after 4096 WAIT cycles one response with rsp_err=1 and rsp_last=1.
REQ-046 The bench SHALL cover a load stall: in_valid toggled every other cycle → exactly 192 acc words counted, WAIT entered on the 192nd.
REQ-047 The bench SHALL cover reset mid-LOAD at word 100 → all outputs 0 and no response; the next job completes normally.
